// File: rtl/fifo_queue_occupancy.sv
`default_nettype none
// ============================================================================
// Module   : fifo_queue_occupancy
// Brief    : FWFT queue, arbitrary depth, occupancy count, almost flags, flush
// Revision : 1.0
// ============================================================================
module fifo_queue_occupancy #(
  parameter int QUEUE_SIZE                 = 8,
  parameter int QUEUE_PTR_WIDTH_IN_BITS    = 3,
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 32,
  parameter int ALMOST_FULL_THRESHOLD      = 6,
  parameter int ALMOST_EMPTY_THRESHOLD     = 2,
  parameter     STORAGE_TYPE               = "LUTRAM"
) (
  input  logic                                  clk_in,
  input  logic                                  reset_in,
  input  logic                                  flush_in,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in,
  input  logic                                  request_valid_in,
  output logic                                  issue_ack_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_out,
  output logic                                  request_valid_out,
  input  logic                                  issue_ack_in,
  output logic                                  is_empty_out,
  output logic                                  is_full_out,
  output logic                                  almost_full_out,
  output logic                                  almost_empty_out,
  output logic [QUEUE_PTR_WIDTH_IN_BITS:0]      occupancy_out
);

  localparam int c_cnt_w = QUEUE_PTR_WIDTH_IN_BITS + 1;
  localparam logic [QUEUE_PTR_WIDTH_IN_BITS-1:0] c_last_idx   = QUEUE_PTR_WIDTH_IN_BITS'(QUEUE_SIZE - 1);
  localparam logic [QUEUE_PTR_WIDTH_IN_BITS-1:0] c_ptr_one    = QUEUE_PTR_WIDTH_IN_BITS'(1);
  localparam logic [QUEUE_PTR_WIDTH_IN_BITS:0]   c_full_count = c_cnt_w'(QUEUE_SIZE);
  localparam logic [QUEUE_PTR_WIDTH_IN_BITS:0]   c_af_count   = c_cnt_w'(ALMOST_FULL_THRESHOLD);
  localparam logic [QUEUE_PTR_WIDTH_IN_BITS:0]   c_ae_count   = c_cnt_w'(ALMOST_EMPTY_THRESHOLD);
  localparam logic [QUEUE_PTR_WIDTH_IN_BITS:0]   c_count_one  = c_cnt_w'(1);

  logic [QUEUE_PTR_WIDTH_IN_BITS-1:0]    r_wr_ptr;
  logic [QUEUE_PTR_WIDTH_IN_BITS-1:0]    r_rd_ptr;
  logic [QUEUE_PTR_WIDTH_IN_BITS:0]      r_count;
  logic [QUEUE_PTR_WIDTH_IN_BITS-1:0]    w_wr_ptr_next;
  logic [QUEUE_PTR_WIDTH_IN_BITS-1:0]    w_rd_ptr_next;
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] w_head;
  logic                                  w_push;
  logic                                  w_pop;
  logic                                  w_wr_en;

  assign is_empty_out      = (r_count == '0);
  assign is_full_out       = (r_count == c_full_count);
  assign almost_full_out   = (r_count >= c_af_count);
  assign almost_empty_out  = (r_count <= c_ae_count);
  assign occupancy_out     = r_count;
  assign request_valid_out = ~is_empty_out;
  assign request_out       = request_valid_out ? w_head : '0;

  // Ack is a pure function of state and producer/flush inputs; the consumer
  // side never frees a slot in time for a same-cycle push.
  assign w_push        = request_valid_in & ~is_full_out & ~flush_in;
  assign issue_ack_out = w_push;
  assign w_pop         = issue_ack_in & request_valid_out & ~flush_in;
  assign w_wr_en       = w_push & ~reset_in;

  // Depth need not be a power of two, so wrap on an explicit compare.
  assign w_wr_ptr_next = (r_wr_ptr == c_last_idx) ? '0 : r_wr_ptr + c_ptr_one;
  assign w_rd_ptr_next = (r_rd_ptr == c_last_idx) ? '0 : r_rd_ptr + c_ptr_one;

  always_ff @(posedge clk_in) begin
    if (reset_in || flush_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_ptr_next;
      if (w_pop)  r_rd_ptr <= w_rd_ptr_next;
      if (w_push && !w_pop)      r_count <= r_count + c_count_one;
      else if (w_pop && !w_push) r_count <= r_count - c_count_one;
    end
  end

  generate
    if (STORAGE_TYPE == "FLOPS") begin : g_flops_storage
      (* ram_style = "registers" *)
      logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] r_mem [QUEUE_SIZE];
      always_ff @(posedge clk_in) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= request_in;
      end
      assign w_head = r_mem[r_rd_ptr];
    end else begin : g_lutram_storage
      (* ram_style = "distributed" *)
      logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] r_mem [QUEUE_SIZE];
      always_ff @(posedge clk_in) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= request_in;
      end
      assign w_head = r_mem[r_rd_ptr];
    end
  endgenerate

endmodule
`default_nettype wire
